// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch engine.
// One memory request is in flight at most; a redirect squashes or drops any
// in-flight response and restarts fetch at the (word-aligned) target.
// Build option: define FETCH_PERF_CNT_EN to enable the stall_cycles counter;
// when undefined the port reads 0 and no counter flops exist.
//
// state | meaning
// IDLE  | no request; issue one next cycle
// REQ   | imem_req high, waiting for imem_gnt
// WAIT  | granted, waiting for imem_rvalid
// VALID | inst/pc hold a live instruction for decode
// DROP  | granted request is stale; swallow its response
module fetch_unit #(
  parameter logic [35:0] RESET_PC = 36'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [35:0] redirect_pc,
  output logic        imem_req,
  output logic [35:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [4:0]  vread1,
  output logic [4:0]  vread2,
  output logic [35:0] pc,
  output logic [35:0] pc_plus_4,
  output logic        inst_valid,
  output logic [31:0] stall_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [4:0]  vread1_q, vread1_d;
  logic [4:0]  vread2_q, vread2_d;
  logic        inst_valid_q, inst_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [35:0] redirect_tgt;

  // Only the word-aligned part of the target is meaningful.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_tgt        = {redirect_pc[35:2], 2'b00};

  // Next-state, next-pc and registered-output computation.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    vread1_d = vread1_q;
    vread2_d = vread2_q;

    case (state_q)
      ST_IDLE: begin
        if (redirect) pc_d = redirect_tgt;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          // Ungranted request is simply withdrawn for a cycle; a granted one
          // leaves a response in flight that must be swallowed.
          state_d = imem_gnt ? ST_DROP : ST_IDLE;
        end else if (imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          inst_d   = imem_rdata;
          vread1_d = imem_rdata[19:15];
          vread2_d = imem_rdata[14:10];
          state_d  = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 36'd4;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) pc_d = redirect_tgt;
        // A response arriving together with a redirect still retires the
        // stale request; waiting on would deadlock with nothing in flight.
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Anything other than VALID presents a bubble to decode.
    if (state_d != ST_VALID) begin
      inst_d   = 32'h0;
      vread1_d = 5'h0;
      vread2_d = 5'h0;
    end
    inst_valid_d = (state_d == ST_VALID);
    imem_req_d   = (state_d == ST_REQ);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      vread1_q     <= 5'h0;
      vread2_q     <= 5'h0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      vread1_q     <= vread1_d;
      vread2_q     <= vread2_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = {pc_q[35:2], 2'b00};
  assign inst       = inst_q;
  assign vread1     = vread1_q;
  assign vread2     = vread2_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus_4  = pc_q + 36'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count decode-stalled cycles holding a live instruction, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_VALID) && stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'h0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a
// transaction-level reference model (pending/discard/holding flags).
module tb_fetch_unit;

  localparam logic [35:0] RESET_PC = 36'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [35:0] redirect_pc;
  logic        imem_req;
  logic [35:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [4:0]  vread1, vread2;
  logic [35:0] pc, pc_plus_4;
  logic        inst_valid;
  logic [31:0] stall_cycles;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .vread1(vread1), .vread2(vread2), .pc(pc),
    .pc_plus_4(pc_plus_4), .inst_valid(inst_valid), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetch pointer plus what the unit is currently doing.
  logic [35:0] m_pc;
  bit          m_req;      // request being presented
  bit          m_pend;     // granted, response outstanding
  bit          m_discard;  // outstanding response is stale
  bit          m_have;     // holding an instruction for decode
  logic [31:0] m_inst;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_req = 0; m_pend = 0; m_discard = 0; m_have = 0;
    m_inst = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic chk_model();
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
    e_inst = m_have ? m_inst : 32'h0;
`ifdef FETCH_PERF_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 32'h0;
`endif
    chk("imem_req",     {35'h0, imem_req},    {35'h0, m_req});
    chk("imem_addr",    imem_addr,            {m_pc[35:2], 2'b00});
    chk("inst_valid",   {35'h0, inst_valid},  {35'h0, m_have});
    chk("inst",         {4'h0, inst},         {4'h0, e_inst});
    chk("vread1",       {31'h0, vread1},      {31'h0, e_inst[19:15]});
    chk("vread2",       {31'h0, vread2},      {31'h0, e_inst[14:10]});
    chk("pc",           pc,                   m_pc);
    chk("pc_plus_4",    pc_plus_4,            m_pc + 36'd4);
    chk("stall_cycles", {4'h0, stall_cycles}, {4'h0, e_cnt});
  endtask

  task automatic chk_reset_vals();
    chk("rst_imem_req",   {35'h0, imem_req},    36'h0);
    chk("rst_imem_addr",  imem_addr,            {RESET_PC[35:2], 2'b00});
    chk("rst_inst",       {4'h0, inst},         36'h0);
    chk("rst_vread1",     {31'h0, vread1},      36'h0);
    chk("rst_vread2",     {31'h0, vread2},      36'h0);
    chk("rst_inst_valid", {35'h0, inst_valid},  36'h0);
    chk("rst_stall_cnt",  {4'h0, stall_cycles}, 36'h0);
    chk("rst_pc",         pc,                   RESET_PC);
    chk("rst_pc_plus_4",  pc_plus_4,            RESET_PC + 36'd4);
  endtask

  // Called in the low clock phase: drive inputs, advance the model, take one
  // edge, check all outputs, return at the following negedge.
  task automatic step(input bit st, input bit rd, input logic [35:0] rpc,
                      input bit g, input bit rv);
    logic [35:0] tgt;
    logic [31:0] rdata;
    rdata       = $urandom;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rdata;
    tgt = {rpc[35:2], 2'b00};

    if (m_have) begin
      if (rd)       begin m_pc = tgt;           m_have = 0; m_req = 1; end
      else if (!st) begin m_pc = m_pc + 36'd4;  m_have = 0; m_req = 1; end
      else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (m_req) begin
      if (rd) begin
        m_pc = tgt; m_req = 0;
        if (g) begin m_pend = 1; m_discard = 1; end
      end else if (g) begin
        m_req = 0; m_pend = 1;
      end
    end else if (m_pend) begin
      if (m_discard) begin
        if (rd) m_pc = tgt;
        if (rv) begin m_pend = 0; m_discard = 0; m_req = 1; end
      end else if (rd) begin
        m_pc = tgt;
        if (rv) begin m_pend = 0; m_req = 1; end
        else m_discard = 1;
      end else if (rv) begin
        m_pend = 0; m_have = 1; m_inst = rdata;
      end
    end else begin
      if (rd) m_pc = tgt;
      m_req = 1;
    end

    @(posedge clk);
    #1;
    chk_model();
    @(negedge clk);
  endtask

  // Zero-wait memory behaviour from the model's view of the bus.
  task automatic zstep(input bit st);
    step(st, 1'b0, 36'h0, m_req, m_pend);
  endtask

  task automatic goto_valid();
    int n = 0;
    while (!m_have && n < 20) begin zstep(1'b0); n++; end
    chk("goto_valid", {35'h0, inst_valid}, 36'h1);
  endtask

  task automatic goto_wait();
    int n = 0;
    while (!(m_pend && !m_discard) && n < 20) begin
      step(1'b0, 1'b0, 36'h0, m_req, m_pend && m_discard);
      n++;
    end
    chk("goto_wait", {34'h0, inst_valid, imem_req}, 36'h0);
  endtask

  initial begin
    logic [63:0] r;
    stall = 0; redirect = 0; redirect_pc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait throughput: requests on cycles 1,4,7; valid on 3,6,9.
    for (int k = 1; k <= 9; k++) begin
      zstep(1'b0);
      chk("tp_req",   {35'h0, imem_req},   {35'h0, (k % 3) == 1});
      chk("tp_valid", {35'h0, inst_valid}, {35'h0, (k % 3) == 0});
      chk("tp_pc",    pc,                  36'(4 * ((k - 1) / 3)));
    end

    // Five stalled cycles in VALID, then consume.
    goto_valid();
    for (int k = 0; k < 5; k++) begin
      zstep(1'b1);
      chk("stall_noreq", {35'h0, imem_req}, 36'h0);
    end
    zstep(1'b0);

    // Redirect while waiting; stale response arrives two cycles later.
    goto_wait();
    step(1'b0, 1'b1, 36'h100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 36'h0,   1'b0, 1'b0);
    step(1'b0, 1'b0, 36'h0,   1'b0, 1'b1);
    chk("drop_inst", {4'h0, inst}, 36'h0);
    chk("drop_addr", imem_addr, 36'h100);
    chk("drop_req",  {35'h0, imem_req}, 36'h1);

    // Redirect wins over stall in VALID.
    goto_valid();
    step(1'b1, 1'b1, 36'h2468, 1'b0, 1'b0);
    chk("rs_valid", {35'h0, inst_valid}, 36'h0);
    chk("rs_addr",  imem_addr, 36'h2468);

    // Address wrap at the top of the 36-bit space.
    goto_valid();
    step(1'b0, 1'b1, 36'hF_FFFF_FFFC, 1'b0, 1'b0);
    chk("wrap_pp4", pc_plus_4, 36'h0);
    goto_valid();
    zstep(1'b0);
    chk("wrap_addr", imem_addr, 36'h0);

    // Asynchronous reset while waiting; late response afterwards is ignored.
    goto_valid();
    zstep(1'b0);
    goto_wait();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 36'h0, 1'b0, 1'b1);
    chk("rst_restart", imem_addr, RESET_PC);
    step(1'b0, 1'b0, 36'h0, 1'b0, 1'b1);
    chk("late_rvalid", {35'h0, inst_valid}, 36'h0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      bit st, rd, g, rv;
      logic [35:0] rpc;
      r   = {$urandom, $urandom};
      st  = ($urandom % 3) == 0;
      rd  = ($urandom % 10) == 0;
      rpc = (($urandom % 8) == 0) ? 36'hF_FFFF_FFFC : r[35:0];
      g   = m_req && ($urandom % 2);
      rv  = m_pend && ($urandom % 2);
      step(st, rd, rpc, g, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 36'h0, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  decode stall; the same signal that holds the fetch/decode pipeline register.
REQ-005 redirect  in  1  taken branch or jump; loads redirect_pc.
REQ-006 redirect_pc  in  36  target address.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  36  request address.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  read data valid.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 inst  out  32  instruction to fetch/decode register.
REQ-013 vread1, vread2  out  5 each  predecoded vector-register read selects.
REQ-014 pc, pc_plus_4  out  36 each  address of inst and that address + 4.
REQ-015 inst_valid  out  1  inst/pc outputs hold a live instruction.
REQ-016 stall_cycles  out  32  performance counter (see Configuration).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, VALID, DROP; one memory request outstanding at most.
REQ-018 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal internal pc_q with bits [1:0] = 0.
REQ-019 IDLE: -> REQ next cycle.
REQ-020 REQ: on imem_gnt -> WAIT; otherwise hold imem_req and imem_addr stable.
REQ-021 WAIT: on imem_rvalid capture imem_rdata -> VALID; imem_rvalid is never asserted in the gnt cycle.
REQ-022 VALID: inst_valid=1; if stall=0, instruction is consumed at this edge, pc_q <= pc_q+4 -> REQ; if stall=1, hold all outputs unchanged.
REQ-023 Outside VALID, inst, vread1, vread2 SHALL be 0 (bubble) and inst_valid 0; pc/pc_plus_4 SHALL track pc_q.
REQ-024 vread1 = inst[19:15], vread2 = inst[14:10]; outputs registered with inst.
REQ-025 pc_plus_4 = pc + 4 modulo 2^36; 36'hF_FFFF_FFFC wraps to 0.
REQ-026 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, VALID) with zero-wait memory.
REQ-027 redirect SHALL have priority over stall and over sequential PC update; pc_q <= {redirect_pc[35:2],2'b00}; inst_valid deasserts next cycle.
REQ-028 redirect in IDLE or VALID -> REQ.
REQ-029 redirect in REQ with imem_gnt=0 -> IDLE (request withdrawn one cycle); with imem_gnt=1 -> DROP.
REQ-030 redirect in WAIT with imem_rvalid=1 -> REQ (data discarded); with imem_rvalid=0 -> DROP.
REQ-031 DROP: discard the pending response; on imem_rvalid -> REQ; redirect in DROP updates pc_q and stays DROP.

Reset
REQ-032 While rst_n=0: state IDLE, pc_q=RESET_PC, imem_req=0, inst=0, vread1/vread2=0, inst_valid=0, stall_cycles=0, pc=RESET_PC, pc_plus_4=RESET_PC+4.
REQ-033 Reset asserted mid-transaction SHALL abandon it; a late imem_rvalid after reset release with no issued request SHALL be ignored.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: stall_cycles increments once per cycle in VALID with stall=1 and redirect=0, saturating at 32'hFFFF_FFFF.
REQ-035 FETCH_PERF_CNT_EN undefined: stall_cycles tied to 0, no counter flops; port list unchanged.

Verification
REQ-036 Reset release, RESET_PC=0, zero-wait memory, stall=0 -> imem_addr 0,4,8 issued on cycles 1,4,7; inst_valid pulses once per 3 cycles with matching pc.
REQ-037 VALID with stall=1 for 5 cycles -> outputs frozen, imem_req=0, stall_cycles=5 (macro on) / 0 (macro off).
REQ-038 redirect_pc=36'h100 in WAIT, rvalid 2 cycles later -> stale data never reaches inst; next imem_addr=36'h100.
REQ-039 redirect and stall both 1 in VALID -> inst_valid=0 next cycle, next request address = redirect_pc.
REQ-040 redirect_pc=36'hF_FFFF_FFFC -> pc_plus_4=0; next sequential imem_addr=0.
REQ-041 rst_n low in WAIT -> all outputs to reset values immediately (asynchronously); fetch restarts at RESET_PC.
